// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller for the 9-bit ALU datapath
// Three-state sequencer: accept, execute, write back; owns the 8 x 9-bit register file.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_instr,
  output logic [8:0]  alu_a,
  output logic [8:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [8:0]  alu_result,
  output logic        done,
  output logic [8:0]  out_result,
  output logic        eq_flag,
  input  logic [2:0]  dbg_addr,
  output logic [8:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0] OP_EQ = 2'b10;

  state_t     state;
  logic [8:0] rf [8];
  logic [1:0] op_q;
  logic [2:0] rd_q;

  logic [1:0] f_op;
  logic [2:0] f_rd;
  logic [2:0] f_ra;
  logic [2:0] f_rb;
  logic [8:0] ra_val;
  logic [8:0] rb_val;
  logic       unused_rsvd;

  assign f_op        = in_instr[11:10];
  assign f_rd        = in_instr[8:6];
  assign f_ra        = in_instr[5:3];
  assign f_rb        = in_instr[2:0];
  assign unused_rsvd = in_instr[9];

  // r0 is hardwired to zero on every read port, whatever its storage holds
  assign ra_val   = (f_ra == 3'd0) ? 9'd0 : rf[f_ra];
  assign rb_val   = (f_rb == 3'd0) ? 9'd0 : rf[f_rb];
  assign dbg_data = (dbg_addr == 3'd0) ? 9'd0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      done       <= 1'b0;
      out_result <= 9'd0;
      eq_flag    <= 1'b0;
      alu_a      <= 9'd0;
      alu_b      <= 9'd0;
      alu_sel    <= 2'd0;
      op_q       <= 2'd0;
      rd_q       <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 9'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= f_op;
            rd_q     <= f_rd;
            alu_a    <= ra_val;
            alu_b    <= rb_val;
            alu_sel  <= f_op;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          out_result <= alu_result;
          done       <= 1'b1;
          state      <= WB;
        end
        WB: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
          if (op_q == OP_EQ) begin
            eq_flag <= out_result[0];
          end else if (rd_q != 3'd0) begin
            rf[rd_q] <= out_result;
          end
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl
// Bench supplies its own combinational ALU; expected values are hand-computed.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_instr;
  logic [8:0]  alu_a;
  logic [8:0]  alu_b;
  logic [1:0]  alu_sel;
  logic [8:0]  alu_result;
  logic        done;
  logic [8:0]  out_result;
  logic        eq_flag;
  logic [2:0]  dbg_addr;
  logic [8:0]  dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] ADD = 2'b00, NAND = 2'b01, EQ = 2'b10, MOV = 2'b11;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .done(done), .out_result(out_result),
    .eq_flag(eq_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 9'd0;
    case (alu_sel)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = ~(alu_a & alu_b);
      2'b10: alu_result = {8'd0, (alu_a == alu_b)};
      2'b11: alu_result = alu_a;
      default: alu_result = 9'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [2:0] addr, input logic [8:0] exp);
    dbg_addr = addr;
    #1;
    chk($sformatf("reg[%0d]", addr), dbg_data, exp);
  endtask

  // Issues one instruction from a negedge and checks the accept/done/ready timeline.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    in_instr = {op, 1'b1, rd, ra, rb};
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 12'hFFF;
    chk("sel_after_accept", alu_sel, op);
    chk("ready_in_exec", in_ready, 1'b0);
    chk("done_in_exec", done, 1'b0);
    @(posedge clk); #1;
    chk("done_in_wb", done, 1'b1);
    chk("ready_in_wb", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("done_after_wb", done, 1'b0);
    chk("ready_after_wb", in_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 12'd0;
    dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", in_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_out_result", out_result, 9'd0);
    chk("rst_eq_flag", eq_flag, 1'b0);
    chk("rst_alu_a", alu_a, 9'd0);
    chk("rst_alu_b", alu_b, 9'd0);
    chk("rst_alu_sel", alu_sel, 2'd0);
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 9'd0);

    // NAND and r0 discard
    issue(NAND, 3'd4, 3'd0, 3'd0);
    rd_chk(3'd4, 9'h1FF);
    issue(NAND, 3'd0, 3'd0, 3'd0);
    chk("nand_r0_out", out_result, 9'h1FF);
    rd_chk(3'd0, 9'd0);

    // Build 1 and 2, then seed r1=1FF, r2=2
    issue(ADD, 3'd6, 3'd4, 3'd4);
    rd_chk(3'd6, 9'h1FE);
    issue(NAND, 3'd6, 3'd6, 3'd6);
    rd_chk(3'd6, 9'h001);
    issue(ADD, 3'd5, 3'd6, 3'd6);
    rd_chk(3'd5, 9'h002);
    issue(MOV, 3'd2, 3'd5, 3'd7);
    issue(MOV, 3'd1, 3'd4, 3'd0);
    rd_chk(3'd1, 9'h1FF);
    rd_chk(3'd2, 9'h002);

    // ADD wrap
    issue(ADD, 3'd3, 3'd1, 3'd2);
    chk("add_alu_a", alu_a, 9'h1FF);
    chk("add_alu_b", alu_b, 9'h002);
    chk("add_out", out_result, 9'h001);
    rd_chk(3'd3, 9'h001);

    // EQ
    issue(MOV, 3'd5, 3'd4, 3'd0);
    issue(EQ, 3'd7, 3'd1, 3'd5);
    chk("eq_true", eq_flag, 1'b1);
    rd_chk(3'd7, 9'd0);
    issue(EQ, 3'd7, 3'd1, 3'd0);
    chk("eq_false", eq_flag, 1'b0);
    rd_chk(3'd7, 9'd0);
    chk("out_held", out_result, 9'd0);

    // Back-to-back dependent chain from r1=1
    issue(MOV, 3'd1, 3'd6, 3'd6);
    rd_chk(3'd1, 9'd1);
    in_valid = 1'b1;
    in_instr = {ADD, 1'b0, 3'd1, 3'd1, 3'd1};
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b2b_ready_c%0d", k), in_ready, (k % 3 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("b2b_done_c%0d", k), done, (k % 3 == 2) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rd_chk(3'd1, 9'd8);
    @(negedge clk);
    chk("b2b_idle_ready", in_ready, 1'b1);
    chk("b2b_no_extra_done", done, 1'b0);

    // Abort: async reset during EXEC of ADD r2,r1,r1
    in_valid = 1'b1;
    in_instr = {ADD, 1'b0, 3'd2, 3'd1, 3'd1};
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_exec_a", alu_a, 9'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_alu_a", alu_a, 9'd0);
    chk("abort_out", out_result, 9'd0);
    rd_chk(3'd1, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", in_ready, 1'b1);
    end
    rd_chk(3'd2, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
